// File: rtl/ram_copy_dma_pkg.sv
// Shared types for the video-side RAM copy/fill engine.
//   dma_state_t   : engine state encoding
//   DMA_MODE_COPY : mode value selecting a RAM-to-RAM copy
//   DMA_MODE_FILL : mode value selecting a constant fill
package ram_copy_dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } dma_state_t;

  localparam logic DMA_MODE_COPY = 1'b0;
  localparam logic DMA_MODE_FILL = 1'b1;

endpackage

// File: rtl/dualport_ram.sv
// Simple true dual-port block RAM, single clock, registered read (1-cycle latency).
// Read-during-write on the same port returns the old word; simultaneous writes to
// the same address from both ports are undefined.
//   clock                        : shared clock
//   address_a/data_a/wren_a/q_a  : port A
//   address_b/data_b/wren_b/q_b  : port B
module dualport_ram #(
  parameter int unsigned width   = 16,
  parameter int unsigned widthad = 10
) (
  input  logic               clock,
  input  logic [widthad-1:0] address_a,
  input  logic [width-1:0]   data_a,
  input  logic               wren_a,
  output logic [width-1:0]   q_a,
  input  logic [widthad-1:0] address_b,
  input  logic [width-1:0]   data_b,
  input  logic               wren_b,
  output logic [width-1:0]   q_b
);

  logic [width-1:0] mem [0:(1 << widthad) - 1];

  always_ff @(posedge clock) begin
    if (wren_a) begin
      mem[address_a] <= data_a;
    end
    if (wren_b) begin
      mem[address_b] <= data_b;
    end
    q_a <= mem[address_a];
    q_b <= mem[address_b];
  end

endmodule

// File: rtl/ram_copy_dma.sv
// Block copy / constant fill engine driving one RAM read port and one RAM write port.
// A start in idle latches mode, bases, length and fill word; reads are issued one per
// unstalled cycle and each write trails its read by one cycle (RAM read latency).
//   clock, reset_n           : clock and synchronous active-low reset
//   start, mode, src_base,
//   dst_base, len, fill_value: transfer request, latched when start is taken in idle
//   hold                     : freezes the engine (no writes, indices frozen)
//   abort                    : cancels an active transfer, no done pulse
//   src_addr, src_q          : source RAM read address / registered read data
//   dst_addr, dst_data,
//   dst_wren                 : destination RAM write port
//   busy, done               : not-idle flag, one-cycle completion pulse
module ram_copy_dma
  import ram_copy_dma_pkg::*;
#(
  parameter int unsigned width   = 16,
  parameter int unsigned widthad = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               mode,
  input  logic [widthad-1:0] src_base,
  input  logic [widthad-1:0] dst_base,
  input  logic [widthad:0]   len,
  input  logic [width-1:0]   fill_value,
  input  logic               hold,
  input  logic               abort,
  output logic [widthad-1:0] src_addr,
  input  logic [width-1:0]   src_q,
  output logic [widthad-1:0] dst_addr,
  output logic [width-1:0]   dst_data,
  output logic               dst_wren,
  output logic               busy,
  output logic               done
);

  localparam logic [widthad:0]   IdxOne  = 1;
  localparam logic [widthad-1:0] AddrOne = 1;
  localparam logic [widthad:0]   LenZero = '0;

  dma_state_t         state_q, state_d;
  logic               mode_q;
  logic [widthad-1:0] src_base_q, dst_base_q;
  logic [widthad:0]   len_q;
  logic [width-1:0]   fill_q;
  logic [widthad:0]   rd_idx_q, rd_idx_d;
  logic [widthad-1:0] wr_idx_q, wr_idx_d;
  logic               valid_q, valid_d;
  logic               latch_cfg;

  logic               active;
  logic               advance;
  logic               stall;
  logic [widthad-1:0] back_off;

  assign active  = (state_q == StRun) || (state_q == StDrain);
  assign advance = active && !hold && !abort;
  assign stall   = active && hold && !abort;

  // While stalled with a read in flight, re-present the address of that read so the
  // registered RAM output keeps the word the pending write still needs.
  assign back_off = {{(widthad - 1){1'b0}}, stall && valid_q};

  assign src_addr = src_base_q + rd_idx_q[widthad-1:0] - back_off;
  assign dst_addr = dst_base_q + wr_idx_q;
  assign dst_wren = valid_q && advance;
  // src_q is already registered inside the RAM, so a plain mux is enough here.
  assign dst_data = (mode_q == DMA_MODE_FILL) ? fill_q : src_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    wr_idx_d  = wr_idx_q;
    valid_d   = valid_q;
    latch_cfg = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch_cfg = 1'b1;
          rd_idx_d  = '0;
          wr_idx_d  = '0;
          valid_d   = 1'b0;
          state_d   = (len == LenZero) ? StDone : StRun;
        end
      end
      StRun: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (!hold) begin
          rd_idx_d = rd_idx_q + IdxOne;
          valid_d  = 1'b1;
          if (valid_q) begin
            wr_idx_d = wr_idx_q + AddrOne;
          end
          if (rd_idx_q == len_q - IdxOne) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (!hold) begin
          wr_idx_d = wr_idx_q + AddrOne;
          valid_d  = 1'b0;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      mode_q     <= DMA_MODE_COPY;
      src_base_q <= '0;
      dst_base_q <= '0;
      len_q      <= '0;
      fill_q     <= '0;
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      valid_q  <= valid_d;
      if (latch_cfg) begin
        mode_q     <= mode;
        src_base_q <= src_base;
        dst_base_q <= dst_base;
        len_q      <= len;
        fill_q     <= fill_value;
      end
    end
  end

endmodule

// File: tb/tb_ram_copy_dma.sv
module tb_ram_copy_dma;
  import ram_copy_dma_pkg::*;

  localparam int W     = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n, start, mode, hold, abort;
  logic [AW-1:0] src_base, dst_base;
  logic [AW:0]   len;
  logic [W-1:0]  fill_value;
  logic [AW-1:0] src_addr, dst_addr;
  logic [W-1:0]  src_q, dst_data;
  logic          dst_wren, busy, done;

  logic [AW-1:0] sb_addr, db_addr;
  logic [W-1:0]  sb_data, sb_q, db_data, db_q, da_q, zero_w;
  logic          sb_wren, db_wren, no_wr;

  ram_copy_dma #(.width(W), .widthad(AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .len(len), .fill_value(fill_value),
    .hold(hold), .abort(abort), .src_addr(src_addr), .src_q(src_q),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_wren(dst_wren),
    .busy(busy), .done(done)
  );

  dualport_ram #(.width(W), .widthad(AW)) src_ram (
    .clock(clock), .address_a(src_addr), .data_a(zero_w), .wren_a(no_wr), .q_a(src_q),
    .address_b(sb_addr), .data_b(sb_data), .wren_b(sb_wren), .q_b(sb_q)
  );

  dualport_ram #(.width(W), .widthad(AW)) dst_ram (
    .clock(clock), .address_a(dst_addr), .data_a(dst_data), .wren_a(dst_wren), .q_a(da_q),
    .address_b(db_addr), .data_b(db_data), .wren_b(db_wren), .q_b(db_q)
  );

  // Reference memories: what each RAM should hold after every transfer.
  logic [W-1:0] src_m [DEPTH];
  logic [W-1:0] dst_m [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc = 0;
  bit mon_on  = 1'b0;
  int rel;
  int wr_cnt, first_wr, last_wr, hold_wr, done_cnt, done_rel;

  always @(posedge clock) cyc++;

  // Observe DMA outputs mid-cycle, relative to the cycle start was driven in.
  always @(negedge clock) begin
    if (mon_on) begin
      rel = cyc - start_cyc;
      if (dst_wren) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = rel;
        last_wr = rel;
        if (hold) hold_wr++;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    wr_cnt = 0; first_wr = -1; last_wr = -1; hold_wr = 0; done_cnt = 0; done_rel = -1;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - start_cyc < r) tick();
  endtask

  // Drive a one-cycle start; returns one cycle later (cycle 1 of the transfer).
  task automatic launch(input logic m, input int sb, input int db, input int l, input int fv);
    mode       = m;
    src_base   = AW'(sb);
    dst_base   = AW'(db);
    len        = (AW + 1)'(l);
    fill_value = W'(fv);
    start      = 1'b1;
    start_cyc  = cyc;
    clear_mon();
    mon_on     = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Expected effect of a complete transfer of the first n of l words.
  task automatic model_xfer(input logic m, input int sb, input int db, input int n,
                            input int fv);
    for (int i = 0; i < n; i++) begin
      dst_m[(db + i) % DEPTH] = (m == DMA_MODE_FILL) ? W'(fv) : src_m[(sb + i) % DEPTH];
    end
  endtask

  task automatic verify_dst(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < DEPTH; i++) begin
      db_addr = AW'(i);
      tick();
      if (db_q !== dst_m[i]) mism++;
    end
    check({tag, " dst contents mismatching words"}, mism, 0);
  endtask

  task automatic finish_op(input string tag, input int l, input int extra);
    int exp_done;
    exp_done = (l == 0) ? 1 : l + 2 + extra;
    for (int i = 0; i < l + extra + 20 && done_cnt == 0; i++) tick();
    check({tag, " done cycle"}, done_rel, exp_done);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " write count"}, wr_cnt, l);
    check({tag, " busy after done"}, busy, 1'b0);
    mon_on = 1'b0;
    verify_dst(tag);
  endtask

  task automatic do_op(input string tag, input logic m, input int sb, input int db,
                       input int l, input int fv);
    launch(m, sb, db, l, fv);
    model_xfer(m, sb, db, l, fv);
    finish_op(tag, l, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; hold = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; len = '0; fill_value = '0;
    sb_addr = '0; sb_data = '0; sb_wren = 1'b0;
    db_addr = '0; db_data = '0; db_wren = 1'b0;
    zero_w = '0; no_wr = 1'b0;
    tick(); tick(); tick();

    check("reset src_addr", src_addr, 0);
    check("reset dst_addr", dst_addr, 0);
    check("reset dst_wren", dst_wren, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);

    // Preload both RAMs through port B.
    sb_wren = 1'b1;
    db_wren = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sb_addr  = AW'(i);
      sb_data  = W'(i) ^ 16'hA5A5;
      src_m[i] = W'(i) ^ 16'hA5A5;
      db_addr  = AW'(i);
      db_data  = W'($urandom);
      dst_m[i] = db_data;
      tick();
    end
    sb_wren = 1'b0;
    db_wren = 1'b0;
    reset_n = 1'b1;
    tick();

    // Basic copy with write window check.
    launch(DMA_MODE_COPY, 'h010, 'h200, 8, 0);
    model_xfer(DMA_MODE_COPY, 'h010, 'h200, 8, 0);
    wait_rel(3);
    check("copy busy while running", busy, 1'b1);
    finish_op("copy8", 8, 0);
    check("copy8 first write cycle", first_wr, 2);
    check("copy8 last write cycle", last_wr, 9);

    do_op("fill wrap", DMA_MODE_FILL, 'h100, 'h3FE, 4, 'hBEEF);
    do_op("len0", DMA_MODE_COPY, 'h020, 'h040, 0, 0);
    do_op("full copy", DMA_MODE_COPY, 'h123, 'h321, DEPTH, 0);

    // Three hold cycles starting at cycle 5.
    launch(DMA_MODE_COPY, 'h040, 'h080, 16, 0);
    model_xfer(DMA_MODE_COPY, 'h040, 'h080, 16, 0);
    wait_rel(5);
    hold = 1'b1;
    tick(); tick(); tick();
    hold = 1'b0;
    finish_op("hold", 16, 3);
    check("hold writes during hold", hold_wr, 0);

    // Abort at cycle 4, then an immediate fresh start.
    launch(DMA_MODE_COPY, 'h300, 'h100, 32, 0);
    model_xfer(DMA_MODE_COPY, 'h300, 'h100, 2, 0);
    wait_rel(4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy at cycle 5", busy, 1'b0);
    check("abort write count", wr_cnt, 2);
    check("abort done pulses", done_cnt, 0);
    do_op("after abort", DMA_MODE_FILL, 'h000, 'h180, 3, 'h1234);

    // Reset in the middle of a transfer.
    launch(DMA_MODE_COPY, 'h000, 'h010, 8, 0);
    model_xfer(DMA_MODE_COPY, 'h000, 'h010, 2, 0);
    wait_rel(3);
    reset_n = 1'b0;
    tick();
    check("midreset src_addr", src_addr, 0);
    check("midreset dst_addr", dst_addr, 0);
    check("midreset dst_wren", dst_wren, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("midreset write count", wr_cnt, 2);
    check("midreset done pulses", done_cnt, 0);
    mon_on = 1'b0;
    verify_dst("midreset");

    // A start while busy must be ignored and must not re-latch anything.
    launch(DMA_MODE_COPY, 'h050, 'h060, 8, 0);
    model_xfer(DMA_MODE_COPY, 'h050, 'h060, 8, 0);
    wait_rel(4);
    start = 1'b1; mode = DMA_MODE_FILL; len = 20; src_base = 'h3F0; dst_base = 'h3F0;
    fill_value = 'hDEAD;
    tick();
    start = 1'b0;
    finish_op("start while busy", 8, 0);

    // Randomised transfers.
    for (int k = 0; k < 6; k++) begin
      logic m;
      int sb, db, l, fv;
      m  = 1'($urandom_range(0, 1));
      sb = int'($urandom_range(0, DEPTH - 1));
      db = int'($urandom_range(0, DEPTH - 1));
      l  = int'($urandom_range(1, 40));
      fv = int'($urandom_range(0, 65535));
      do_op($sformatf("random%0d", k), m, sb, db, l, fv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
